sfu_seq: RTL

Parametrised successor of the special-function unit. Sequences per-vector LayerNorm-affine, RoPE and residual-add operations over `DIM` lanes. Element-wise add/sub runs on an internal lane ALU; all multiplies are offloaded to the shared vector PE (VPE) over a valid/ready request port and a pulsed response port. It sits between the token buffer and the VPE, with valid/ready handshakes on both input and output.

---
 rtl/sfu_seq.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/sfu_seq.sv
// sfu_seq: sequences LayerNorm-affine, RoPE and residual-add over DIM lanes; multiplies go to the shared VPE.
// Define SFU_SAT_EN for saturating add/sub/negate; the default build wraps in two's complement.
module sfu_seq #(
  parameter int DIM    = 128,
  parameter int DATA_W = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [1:0]                        in_mode,
  input  logic [DIM-1:0][DATA_W-1:0]        in_x,
  input  logic [DIM-1:0][DATA_W-1:0]        in_aux,
  input  logic [DATA_W-1:0]                 in_mean,
  input  logic [DATA_W-1:0]                 in_scale,
  input  logic [DATA_W-1:0]                 in_beta,
  input  logic [DIM/2-1:0][DATA_W-1:0]      in_sin,
  input  logic [DIM/2-1:0][DATA_W-1:0]      in_cos,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [DIM-1:0][DATA_W-1:0]        out_y,
  output logic                              vpe_req_valid,
  input  logic                              vpe_req_ready,
  output logic                              vpe_mode,
  output logic [DIM-1:0][DATA_W-1:0]        vpe_vec1,
  output logic [DIM-1:0][DATA_W-1:0]        vpe_vec2,
  output logic [DATA_W-1:0]                 vpe_sca,
  input  logic                              vpe_rsp_valid,
  input  logic [DIM-1:0][DATA_W-1:0]        vpe_rsp_vec,
  output logic                              busy,
  output logic                              err,
  input  logic                              err_clr
);

  localparam logic [1:0] MODE_LN   = 2'b00;
  localparam logic [1:0] MODE_ROPE = 2'b01;
  localparam logic [1:0] MODE_ILL  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_ALU1, S_VREQ1, S_VWAIT1, S_VREQ2, S_VWAIT2, S_ALU2, S_OUT
  } state_t;

  typedef logic [DIM-1:0][DATA_W-1:0] vec_t;

`ifdef SFU_SAT_EN
  localparam logic [DATA_W-1:0] MAX_V = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] MIN_V = {1'b1, {(DATA_W-1){1'b0}}};
`endif

  function automatic logic [DATA_W-1:0] aluOp(input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b,
                                              input logic              sub);
`ifdef SFU_SAT_EN
    logic [DATA_W:0] s;
    s = sub ? ({a[DATA_W-1], a} - {b[DATA_W-1], b}) : ({a[DATA_W-1], a} + {b[DATA_W-1], b});
    if (s[DATA_W] != s[DATA_W-1]) return s[DATA_W] ? MIN_V : MAX_V;
    return s[DATA_W-1:0];
`else
    return sub ? (a - b) : (a + b);
`endif
  endfunction

  function automatic logic [DATA_W-1:0] negate(input logic [DATA_W-1:0] a);
`ifdef SFU_SAT_EN
    return (a == MIN_V) ? MAX_V : ('0 - a);
`else
    return '0 - a;
`endif
  endfunction

  state_t                       r_state, w_nextState;
  vec_t                         r_x, r_aux, r_p, r_q, r_y;
  logic [DATA_W-1:0]            r_mean, r_scale, r_beta;
  logic [DIM/2-1:0][DATA_W-1:0] r_sin, r_cos;
  logic [1:0]                   r_mode;
  logic                         r_err, r_vpeOutstanding;
  vec_t                         w_xRot, w_cosRep, w_sinRep, w_alu;
  logic                         w_accept, w_inWait, w_errSet;

  assign w_accept = in_valid && (r_state == S_IDLE);
  assign w_inWait = (r_state == S_VWAIT1) || (r_state == S_VWAIT2);
  assign busy     = (r_state != S_IDLE);
  assign err      = r_err;
  assign out_y    = r_y;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState   = r_state;
    in_ready      = 1'b0;
    out_valid     = 1'b0;
    vpe_req_valid = 1'b0;
    vpe_mode      = 1'b0;
    vpe_vec1      = '0;
    vpe_vec2      = '0;
    vpe_sca       = '0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          case (in_mode)
            MODE_LN:   w_nextState = S_ALU1;
            MODE_ROPE: w_nextState = S_VREQ1;
            MODE_ILL:  w_nextState = S_IDLE;
            default:   w_nextState = S_ALU2;
          endcase
        end
      end
      S_ALU1: w_nextState = S_VREQ1;
      S_VREQ1: begin
        vpe_req_valid = 1'b1;
        if (r_mode == MODE_ROPE) begin
          vpe_mode = 1'b1;
          vpe_vec1 = r_x;
          vpe_vec2 = w_cosRep;
        end else begin
          vpe_vec1 = r_p;
          vpe_sca  = r_scale;
        end
        if (vpe_req_ready) w_nextState = S_VWAIT1;
      end
      S_VWAIT1: if (vpe_rsp_valid) w_nextState = (r_mode == MODE_ROPE) ? S_VREQ2 : S_ALU2;
      S_VREQ2: begin
        vpe_req_valid = 1'b1;
        vpe_mode      = 1'b1;
        vpe_vec1      = w_xRot;
        vpe_vec2      = w_sinRep;
        if (vpe_req_ready) w_nextState = S_VWAIT2;
      end
      S_VWAIT2: if (vpe_rsp_valid) w_nextState = S_ALU2;
      S_ALU2:   w_nextState = S_OUT;
      S_OUT: begin
        out_valid = 1'b1;
        if (out_ready) w_nextState = S_IDLE;
      end
      default: w_nextState = S_IDLE;
    endcase
  end

  // RoPE pairs lanes (2k, 2k+1): rotated x is (-x[2k+1], x[2k]) and each table entry feeds both lanes
  always_comb begin
    w_xRot   = '0;
    w_cosRep = '0;
    w_sinRep = '0;
    for (int k = 0; k < DIM/2; k++) begin
      w_xRot[2*k]     = negate(r_x[2*k+1]);
      w_xRot[2*k+1]   = r_x[2*k];
      w_cosRep[2*k]   = r_cos[k];
      w_cosRep[2*k+1] = r_cos[k];
      w_sinRep[2*k]   = r_sin[k];
      w_sinRep[2*k+1] = r_sin[k];
    end
  end

  always_comb begin
    w_alu = '0;
    for (int i = 0; i < DIM; i++) begin
      if (r_state == S_ALU1) begin
        w_alu[i] = aluOp(r_x[i], r_mean, 1'b1);
      end else begin
        case (r_mode)
          MODE_LN:   w_alu[i] = aluOp(r_p[i], r_beta, 1'b0);
          MODE_ROPE: w_alu[i] = aluOp(r_p[i], r_q[i], 1'b0);
          default:   w_alu[i] = aluOp(r_x[i], r_aux[i], 1'b0);
        endcase
      end
    end
  end

  // r_p carries t into the first VPE request, then holds the first VPE result (u or p)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x     <= '0;
      r_aux   <= '0;
      r_p     <= '0;
      r_q     <= '0;
      r_y     <= '0;
      r_mean  <= '0;
      r_scale <= '0;
      r_beta  <= '0;
      r_sin   <= '0;
      r_cos   <= '0;
      r_mode  <= '0;
    end else begin
      if (w_accept) begin
        r_x     <= in_x;
        r_aux   <= in_aux;
        r_mean  <= in_mean;
        r_scale <= in_scale;
        r_beta  <= in_beta;
        r_sin   <= in_sin;
        r_cos   <= in_cos;
        r_mode  <= in_mode;
      end
      case (r_state)
        S_ALU1:   r_p <= w_alu;
        S_VWAIT1: if (vpe_rsp_valid) r_p <= vpe_rsp_vec;
        S_VWAIT2: if (vpe_rsp_valid) r_q <= vpe_rsp_vec;
        S_ALU2:   r_y <= w_alu;
        default:  ;
      endcase
    end
  end

  // Deliberately outside rst_n: remembers a request the VPE accepted before an abort so its late response is not flagged
  always_ff @(posedge clk) begin
    if (vpe_rsp_valid)                      r_vpeOutstanding <= 1'b0;
    else if (vpe_req_valid && vpe_req_ready) r_vpeOutstanding <= 1'b1;
  end

  assign w_errSet = (w_accept && (in_mode == MODE_ILL)) ||
                    (vpe_rsp_valid && !w_inWait && !r_vpeOutstanding);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_err <= 1'b0;
    else if (w_errSet) r_err <= 1'b1;
    else if (err_clr)  r_err <= 1'b0;
  end

endmodule
